// File: rtl/fft_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_packer
// Purpose  : Ping-pong packer turning a serial complex stream into N-lane frames
//            for the downstream FFT. Define PAK_DSP_FRAME_BITREV_EN for
//            bit-reversed lane placement (DIT FFT input order).
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*DATA_WIDTH-1:0] src_data_in,
  input  logic                    src_valid_in,
  output logic                    src_ready_out,
  input  logic                    flush,
  output logic [N*DATA_WIDTH-1:0] dst_real_out,
  output logic [N*DATA_WIDTH-1:0] dst_imag_out,
  output logic                    dst_valid_out,
  input  logic                    dst_ready_in,
  output logic [$clog2(N):0]      fill_count
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = IDX_W + 1;

  logic [DATA_WIDTH-1:0] r_real_mem [2][N];
  logic [DATA_WIDTH-1:0] r_imag_mem [2][N];
  logic [1:0]            r_bank_full;
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic [IDX_W-1:0]      r_wr_idx;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_flush_close;
  logic                  w_close;
  logic                  w_release;
  logic [CNT_W-1:0]      w_zero_from;
  logic [1:0]            w_full_next;

  function automatic logic [IDX_W-1:0] lane_of(input logic [IDX_W-1:0] pos);
    logic [IDX_W-1:0] lane;
`ifdef PAK_DSP_FRAME_BITREV_EN
    for (int b = 0; b < IDX_W; b++) begin
      lane[b] = pos[IDX_W-1-b];
    end
`else
    lane = pos;
`endif
    return lane;
  endfunction

  assign src_ready_out = !rst && !r_bank_full[r_wr_bank];
  assign dst_valid_out = r_bank_full[r_rd_bank];
  assign fill_count    = {1'b0, r_wr_idx};

  assign w_accept      = src_valid_in && src_ready_out;
  assign w_last        = (r_wr_idx == IDX_W'(N - 1));
  assign w_flush_close = flush && ((r_wr_idx != '0) || w_accept);
  assign w_close       = (w_accept && w_last) || w_flush_close;
  assign w_release     = dst_valid_out && dst_ready_in;
  // First frame position that flush padding clears; the same-cycle sample survives.
  assign w_zero_from   = {1'b0, r_wr_idx} + CNT_W'(w_accept);

  always_comb begin
    w_full_next = r_bank_full;
    if (w_release) begin
      w_full_next[r_rd_bank] = 1'b0;
    end
    if (w_close) begin
      w_full_next[r_wr_bank] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank_full <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_idx    <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int p = 0; p < N; p++) begin
          r_real_mem[b][p] <= '0;
          r_imag_mem[b][p] <= '0;
        end
      end
    end else begin
      if (w_flush_close) begin
        for (int p = 0; p < N; p++) begin
          if (CNT_W'(p) >= w_zero_from) begin
            r_real_mem[r_wr_bank][lane_of(IDX_W'(p))] <= '0;
            r_imag_mem[r_wr_bank][lane_of(IDX_W'(p))] <= '0;
          end
        end
      end
      if (w_accept) begin
        r_real_mem[r_wr_bank][lane_of(r_wr_idx)] <= src_data_in[DATA_WIDTH-1:0];
        r_imag_mem[r_wr_bank][lane_of(r_wr_idx)] <= src_data_in[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      if (w_close) begin
        r_wr_idx  <= '0;
        r_wr_bank <= ~r_wr_bank;
      end else if (w_accept) begin
        r_wr_idx  <= r_wr_idx + 1'b1;
      end
      if (w_release) begin
        r_rd_bank <= ~r_rd_bank;
      end
      r_bank_full <= w_full_next;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    assign dst_real_out[k*DATA_WIDTH +: DATA_WIDTH] = dst_valid_out ? r_real_mem[r_rd_bank][k] : '0;
    assign dst_imag_out[k*DATA_WIDTH +: DATA_WIDTH] = dst_valid_out ? r_imag_mem[r_rd_bank][k] : '0;
  end

endmodule
`default_nettype wire
